// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between internal logic and the buffered UART transmitter.
// The master offers tx_data/tx_start and the transmitter answers with tx_rdy.
interface uart_tx_buffered_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_rdy;

  modport master (output tx_data, output tx_start, input tx_rdy);
  modport slave  (input tx_data, input tx_start, output tx_rdy);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter, LSB first, fixed BAUD_DIV clocks per bit.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO between the handshake and the shifter.
module uart_tx_buffered #(
  parameter int unsigned  BAUD_DIV   = 434,
  parameter int unsigned  FIFO_DEPTH = 4,
  localparam int unsigned CntW       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_buffered_if.slave host,
  output logic              uart_tx,
  output logic              tx_done,
  output logic              tx_ovf,
  output logic [CntW-1:0]   fifo_cnt
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [8:0]  shift_q, shift_d;
  logic        uart_tx_q, uart_tx_d;
  logic        tx_done_q, tx_done_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        baud_tc;
  logic        push;
  logic        load;
  logic        avail;
  logic [7:0]  avail_data;

  assign baud_tc = (baud_q == 16'(BAUD_DIV - 1));
  assign push    = host.tx_start && host.tx_rdy;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;

  // Ready comes from the registered count, so a full FIFO refuses a push even on a pop edge.
  assign host.tx_rdy = (cnt_q < CntW'(FIFO_DEPTH));
  assign avail       = (cnt_q != '0);
  assign avail_data  = mem_q[rd_ptr_q];
  assign fifo_cnt    = cnt_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= host.tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (load) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, load})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: ;
      endcase
    end
  end
`else
  // Unbuffered: an accepted byte goes straight into the shifter.
  assign host.tx_rdy = (state_q == StIdle);
  assign avail       = push;
  assign avail_data  = host.tx_data;
  assign fifo_cnt    = '0;
`endif

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_done_d = 1'b0;
    load      = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (avail) load = 1'b1;
      end
      StStart: begin
        if (baud_tc) state_d = StData;
      end
      StData: begin
        if (baud_tc) begin
          if (bit_q == 3'd7) state_d = StStop;
          else bit_d = bit_q + 3'd1;
        end
      end
      StStop: begin
        if (baud_tc) begin
          tx_done_d = 1'b1;
          if (avail) load = 1'b1;
          else state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle) baud_d = baud_tc ? 16'd0 : baud_q + 16'd1;
    if (baud_tc && (state_q inside {StStart, StData})) shift_d = {1'b1, shift_q[8:1]};

    // Loading restarts the frame on this edge, giving back-to-back frames from STOP.
    if (load) begin
      state_d = StStart;
      shift_d = {avail_data, 1'b0};
      baud_d  = '0;
      bit_d   = '0;
    end

    uart_tx_d = (state_d inside {StStart, StData}) ? shift_d[0] : 1'b1;
    tx_ovf_d  = tx_ovf_q | (host.tx_start & ~host.tx_rdy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '1;
      uart_tx_q <= 1'b1;
      tx_done_q <= 1'b0;
      tx_ovf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      uart_tx_q <= uart_tx_d;
      tx_done_q <= tx_done_d;
      tx_ovf_q  <= tx_ovf_d;
    end
  end

  assign uart_tx = uart_tx_q;
  assign tx_done = tx_done_q;
  assign tx_ovf  = tx_ovf_q;

endmodule
